// File: rtl/axi_llc_pkg.sv
// Shared types for the LLC eviction issue path: the default-width miss
// descriptor and the issue-stage FSM encoding.
package axi_llc_pkg;

  localparam int unsigned DefSetAssociativity = 8;
  localparam int unsigned DefIndexLength      = 8;
  localparam int unsigned DefTagLength        = 20;

  typedef logic [DefSetAssociativity-1:0] way_ind_t;

  typedef struct packed {
    way_ind_t                  way;
    logic                      evict;
    logic [DefIndexLength-1:0] index;
    logic [DefTagLength-1:0]   old_tag;
    logic [DefTagLength-1:0]   new_tag;
  } evict_desc_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    RF   = 2'd2
  } evict_issue_state_e;

endpackage

// File: rtl/axi_llc_sat_cnt.sv
// Saturating up-counter: sticks at all-ones, clear wins over increment.
module axi_llc_sat_cnt #(
  parameter int unsigned Width = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  input  logic             clr_i,
  output logic [Width-1:0] q_o
);

  localparam logic [Width-1:0] One = Width'(1);

  logic [Width-1:0] cnt_q, cnt_d;

  // Next count: clear, saturating increment, or hold.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + One;
    end
  end

  // Count register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign q_o = cnt_q;

endmodule

// File: rtl/axi_llc_evict_issue.sv
// Issues one captured miss decision at a time: dirty victims send a
// write-back descriptor first and only then the refill descriptor, so a line
// is never refilled before its dirty data has left. Clean victims refill only.
module axi_llc_evict_issue
  import axi_llc_pkg::*;
#(
  parameter int unsigned SetAssociativity = 8,
  parameter int unsigned IndexLength      = 8,
  parameter int unsigned TagLength        = 20,
  parameter int unsigned CntWidth         = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        miss_valid_i,
  output logic                        miss_ready_o,
  input  logic [SetAssociativity-1:0] way_ind_i,
  input  logic                        evict_i,
  input  logic [IndexLength-1:0]      index_i,
  input  logic [TagLength-1:0]        old_tag_i,
  input  logic [TagLength-1:0]        new_tag_i,
  output logic                        wb_valid_o,
  input  logic                        wb_ready_i,
  output logic [TagLength-1:0]        wb_tag_o,
  output logic [IndexLength-1:0]      wb_index_o,
  output logic [SetAssociativity-1:0] wb_way_o,
  output logic                        rf_valid_o,
  input  logic                        rf_ready_i,
  output logic [TagLength-1:0]        rf_tag_o,
  output logic [IndexLength-1:0]      rf_index_o,
  output logic [SetAssociativity-1:0] rf_way_o,
  output logic                        busy_o,
  output logic [CntWidth-1:0]         evict_cnt_o,
  output logic                        err_o
);

  typedef struct packed {
    logic [SetAssociativity-1:0] way;
    logic                        evict;
    logic [IndexLength-1:0]      index;
    logic [TagLength-1:0]        old_tag;
    logic [TagLength-1:0]        new_tag;
  } desc_t;

  evict_issue_state_e          state_q, state_d;
  // Holds the dirty-miss descriptor; loaded only for dirty victims so the
  // write-back bus keeps its last value across clean misses.
  desc_t                       desc_q, desc_d;
  logic [TagLength-1:0]        rf_tag_q, rf_tag_d;
  logic [IndexLength-1:0]      rf_index_q, rf_index_d;
  logic [SetAssociativity-1:0] rf_way_q, rf_way_d;
  logic                        err_q, err_d;

  logic accept, way_ok, wb_fire;

  assign accept  = miss_valid_i && (state_q == IDLE);
  assign way_ok  = $onehot(way_ind_i);
  assign wb_fire = (state_q == WB) && wb_ready_i;

  // FSM and descriptor next-state; refill bus loads on entry to RF only.
  always_comb begin
    state_d    = state_q;
    desc_d     = desc_q;
    rf_tag_d   = rf_tag_q;
    rf_index_d = rf_index_q;
    rf_way_d   = rf_way_q;
    err_d      = err_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (!way_ok) begin
            err_d = 1'b1;
          end else if (evict_i) begin
            desc_d.way     = way_ind_i;
            desc_d.evict   = evict_i;
            desc_d.index   = index_i;
            desc_d.old_tag = old_tag_i;
            desc_d.new_tag = new_tag_i;
            state_d        = WB;
          end else begin
            rf_tag_d   = new_tag_i;
            rf_index_d = index_i;
            rf_way_d   = way_ind_i;
            state_d    = RF;
          end
        end
      end
      WB: begin
        if (wb_ready_i) begin
          rf_tag_d   = desc_q.new_tag;
          rf_index_d = desc_q.index;
          rf_way_d   = desc_q.way;
          state_d    = RF;
        end
      end
      RF: begin
        if (rf_ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, descriptor and sticky error registers; reset clears all of them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      desc_q     <= '0;
      rf_tag_q   <= '0;
      rf_index_q <= '0;
      rf_way_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      desc_q     <= desc_d;
      rf_tag_q   <= rf_tag_d;
      rf_index_q <= rf_index_d;
      rf_way_q   <= rf_way_d;
      err_q      <= err_d;
    end
  end

  // Count completed write-backs; the stored evict flag qualifies the count.
  axi_llc_sat_cnt #(
    .Width (CntWidth)
  ) u_evict_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (wb_fire && desc_q.evict),
    .clr_i (1'b0),
    .q_o   (evict_cnt_o)
  );

  assign miss_ready_o = (state_q == IDLE);
  assign busy_o       = (state_q != IDLE);
  assign wb_valid_o   = (state_q == WB);
  assign rf_valid_o   = (state_q == RF);
  assign wb_tag_o     = desc_q.old_tag;
  assign wb_index_o   = desc_q.index;
  assign wb_way_o     = desc_q.way;
  assign rf_tag_o     = rf_tag_q;
  assign rf_index_o   = rf_index_q;
  assign rf_way_o     = rf_way_q;
  assign err_o        = err_q;

  a_wb_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    wb_valid_o |-> $onehot(wb_way_o));
  a_rf_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
    rf_valid_o |-> $onehot(rf_way_o));
  a_exclusive: assert property (@(posedge clk_i) disable iff (rst_i)
    !(wb_valid_o && rf_valid_o));
  a_wb_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (wb_valid_o && !wb_ready_i) |=>
      (wb_valid_o && $stable({wb_tag_o, wb_index_o, wb_way_o})));
  a_rf_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (rf_valid_o && !rf_ready_i) |=>
      (rf_valid_o && $stable({rf_tag_o, rf_index_o, rf_way_o})));

endmodule
